zongxian_arbiter: RTL and testbench
===================================

# zongxian_arbiter

Round-robin arbiter and sequencer for the shared 8-bit system bus ("zongxian"). It accepts requests from `N_REQ` masters and grants the bus to exactly one of them at a time. It forwards the owner's data beats onto the bus as registered outputs and bounds each tenure with a beat limit. It sits between the bus masters and the `debug_zongxian` bus datapath, which consumes `bus_data`/`bus_valid`.

## Interface
Parameters:
- `N_REQ`, 4, number of requesting masters (2..8)
- `DATA_W`, 8, bus data width
- `MAX_BEATS`, 8, maximum valid beats per tenure before forced release (≥1)

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in `N_REQ`: level request per master. Must be held until that master is granted.
- `valid_in` in `N_REQ`: beat-valid per master. Sampled only for the current owner.
- `last_in` in `N_REQ`: final-beat marker per master. Meaningful only with `valid_in`.
- `data_in` in `N_REQ*DATA_W`: master data. Master i occupies bits [i*DATA_W +: DATA_W].
- `gnt` out `N_REQ`: one-hot grant, or all zero.
- `bus_owner` out `clog2(N_REQ)`: index of the current or most recent owner.
- `bus_data` out `DATA_W`: registered forwarded data.
- `bus_valid` out 1: registered forwarded valid.
- `busy` out 1: high while in state OWN.
- `timeout` out 1: one-cycle pulse when a tenure is force-ended by the beat limit.

## Operation
- The state machine has three states: IDLE, OWN, TURN.
- IDLE or TURN, with any `req` bit set:
  - The winner is the first set bit at or after `ptr`, scanning upward modulo `N_REQ`.
  - At the next edge: `gnt` = one-hot of the winner; `bus_owner` = winner; `ptr` = winner+1 (mod `N_REQ`); `beat_cnt` = 0; state → OWN.
- IDLE or TURN, with no request: state → IDLE and `gnt` = 0.
- OWN, each edge (o = owner):
  - `req[o]`=0 → abort. State → TURN, `gnt` = 0, `bus_valid` = 0. That cycle's data is dropped.
  - Otherwise `bus_valid` ← `valid_in[o]` and `bus_data` ← `data_in[o]`. `bus_data` holds its value when invalid.
  - If `valid_in[o]`, then `beat_cnt` increments.
  - If `valid_in[o]` and `last_in[o]` → normal end. State → TURN, `gnt` = 0.
  - Else if `valid_in[o]` and `beat_cnt`==`MAX_BEATS`-1 → forced end. State → TURN, `gnt` = 0, `timeout` pulses for one cycle.
- A `last_in` beat that coincides with the limit beat is a normal end; `timeout` stays 0.
- `valid_in`, `last_in` and `data_in` of non-owners are ignored in every state.
- In TURN, `bus_valid` = 0.
- The pointer guarantees fairness: a continuously requesting master waits at most `N_REQ`-1 tenures.
- Reset values: state IDLE, `gnt`=0, `bus_owner`=0, `bus_data`=0, `bus_valid`=0, `busy`=0, `timeout`=0, `ptr`=0, `beat_cnt`=0.
- Reset asserted mid-tenure: all outputs return to the reset values immediately, asynchronously. The tenure is discarded.

## Timing
- Request to grant: `req` sampled high at edge k → `gnt` high in the cycle after edge k. One cycle latency from IDLE.
- Owner beat to bus: owner beat in cycle c → `bus_valid`/`bus_data` present in cycle c+1.
- Last beat to re-grant: last beat in cycle c → `gnt` low in c+1 (TURN) → next grant visible from c+2. The minimum gap between grants is exactly one cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.
- `busy` equals |`gnt`.

## Structure
- Package `zongxian_pkg`:
  - state enum {IDLE, OWN, TURN}
  - `ZX_DATA_W` = 8
  - the `clog2` helper function for owner and count widths
- Sub-module `zx_rr_picker`: purely combinational. Inputs `req` and `ptr`; outputs `winner` index and `any`.
- `zongxian_arbiter` holds the state register, `ptr`, `beat_cnt` and the output registers.

## Test plan
- Reset, then `req`=4'b0101 held, each master sends one beat with `last_in`:
  - grants go 0, then 2, then 0, ...
  - each `gnt` is high for 2 cycles with one TURN cycle between grants.
- All four masters request continuously with single-beat tenures → grant order 0,1,2,3,0, each tenure 2 cycles.
- Master 1 streams `data_in` 8'h10, 8'h11, ... without `last_in` → exactly 8 beats appear on `bus_data`, `timeout` pulses once in the cycle after beat 8, and `gnt` drops.
- Master 2 sends `valid_in` with `last_in` on its 8th beat → normal end with `timeout`=0.
- Master 3 is owner and drops `req` mid-stream with `valid_in`=1 → no `bus_valid` that cycle, and state goes to TURN.
- Assert `rst_n`=0 mid-tenure, between clock edges → `gnt`, `bus_valid` and `busy` are 0 immediately. After release, first grant goes to the lowest requesting index.

Source files
------------

// File: rtl/zongxian_pkg.sv
// Shared types and helpers for the zongxian bus arbiter slice.
package zongxian_pkg;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } zx_state_e;

  localparam int ZX_DATA_W = 8;

  // Ceiling log2, never below 1 so every derived vector has a legal width.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((32'sd1 <<< w) < value) begin
      w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/zx_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr,
// scanning upward and wrapping modulo N_REQ.
module zx_rr_picker
  import zongxian_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [PW-1:0]    winner,
  output logic             any
);

  // Walk the request vector starting at ptr; the first hit wins.
  always_comb begin
    logic [PW:0]   sum_s;
    logic [PW-1:0] idx_s;
    winner = {PW{1'b0}};
    any    = 1'b0;
    sum_s  = {(PW+1){1'b0}};
    idx_s  = {PW{1'b0}};
    for (int off = 0; off < N_REQ; off++) begin
      sum_s = {1'b0, ptr} + (PW+1)'(off);
      if (sum_s >= (PW+1)'(N_REQ)) begin
        sum_s = sum_s - (PW+1)'(N_REQ);
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[PW-1:0];
      if (!any && req[idx_s]) begin
        any    = 1'b1;
        winner = idx_s;
      end else begin
        winner = winner;
      end
    end
  end

endmodule

// File: rtl/zongxian_arbiter.sv
// Round-robin arbiter and beat sequencer for the shared zongxian bus.
// All outputs are registered; the owner's beats reach the bus one cycle later.
module zongxian_arbiter
  import zongxian_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = ZX_DATA_W,
  parameter int MAX_BEATS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        valid_in,
  input  logic [N_REQ-1:0]        last_in,
  input  logic [N_REQ*DATA_W-1:0] data_in,
  output logic [N_REQ-1:0]        gnt,
  output logic [clog2(N_REQ)-1:0] bus_owner,
  output logic [DATA_W-1:0]       bus_data,
  output logic                    bus_valid,
  output logic                    busy,
  output logic                    timeout
);

  localparam int PW = clog2(N_REQ);
  localparam int CW = clog2(MAX_BEATS + 1);

  zx_state_e         state_r, state_s;
  logic [PW-1:0]     ptr_r, ptr_s;
  logic [CW-1:0]     beat_cnt_r, beat_cnt_s;
  logic [N_REQ-1:0]  gnt_s;
  logic [PW-1:0]     owner_s;
  logic [DATA_W-1:0] data_s;
  logic              valid_s;
  logic              timeout_s;
  logic [PW-1:0]     winner_s;
  logic              any_s;

  zx_rr_picker #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_picker (
    .req    (req),
    .ptr    (ptr_r),
    .winner (winner_s),
    .any    (any_s)
  );

  // Next-state and next-output decode; only the owner's lanes are looked at.
  always_comb begin
    state_s    = state_r;
    ptr_s      = ptr_r;
    beat_cnt_s = beat_cnt_r;
    gnt_s      = gnt;
    owner_s    = bus_owner;
    data_s     = bus_data;
    valid_s    = 1'b0;
    timeout_s  = 1'b0;
    case (state_r)
      IDLE, TURN: begin
        if (any_s) begin
          state_s    = OWN;
          gnt_s      = {{(N_REQ-1){1'b0}}, 1'b1} << winner_s;
          owner_s    = winner_s;
          beat_cnt_s = {CW{1'b0}};
          if (winner_s == PW'(N_REQ - 1)) begin
            ptr_s = {PW{1'b0}};
          end else begin
            ptr_s = winner_s + PW'(1);
          end
        end else begin
          state_s = IDLE;
          gnt_s   = {N_REQ{1'b0}};
        end
      end
      OWN: begin
        if (!req[bus_owner]) begin
          // Owner withdrew: drop this cycle's beat and hand the bus back.
          state_s = TURN;
          gnt_s   = {N_REQ{1'b0}};
        end else begin
          valid_s = valid_in[bus_owner];
          if (valid_in[bus_owner]) begin
            data_s     = data_in[int'(bus_owner) * DATA_W +: DATA_W];
            beat_cnt_s = beat_cnt_r + CW'(1);
            if (last_in[bus_owner]) begin
              state_s = TURN;
              gnt_s   = {N_REQ{1'b0}};
            end else if (beat_cnt_r == CW'(MAX_BEATS - 1)) begin
              state_s   = TURN;
              gnt_s     = {N_REQ{1'b0}};
              timeout_s = 1'b1;
            end else begin
              state_s = OWN;
            end
          end else begin
            state_s = OWN;
          end
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = {N_REQ{1'b0}};
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Pointer, beat counter and registered bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r      <= {PW{1'b0}};
      beat_cnt_r <= {CW{1'b0}};
      gnt        <= {N_REQ{1'b0}};
      bus_owner  <= {PW{1'b0}};
      bus_data   <= {DATA_W{1'b0}};
      bus_valid  <= 1'b0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      ptr_r      <= ptr_s;
      beat_cnt_r <= beat_cnt_s;
      gnt        <= gnt_s;
      bus_owner  <= owner_s;
      bus_data   <= data_s;
      bus_valid  <= valid_s;
      busy       <= |gnt_s;
      timeout    <= timeout_s;
    end
  end

endmodule

// File: tb/tb_zongxian_arbiter.sv
// Directed self-checking bench for zongxian_arbiter.
module tb_zongxian_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, valid_in, last_in;
  logic [31:0] data_in;
  logic [3:0]  gnt;
  logic [1:0]  bus_owner;
  logic [7:0]  bus_data;
  logic        bus_valid, busy, timeout;

  int checks = 0;
  int errors = 0;

  zongxian_arbiter #(.N_REQ(4), .DATA_W(8), .MAX_BEATS(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .valid_in(valid_in), .last_in(last_in),
    .data_in(data_in), .gnt(gnt), .bus_owner(bus_owner), .bus_data(bus_data),
    .bus_valid(bus_valid), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; req = 4'b0; valid_in = 4'b0; last_in = 4'b0; data_in = 32'h0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req = 4'b0; valid_in = 4'b0; last_in = 4'b0; data_in = 32'h0;
    tick();
    checks++;
    if ({gnt, bus_owner, bus_data, bus_valid, busy, timeout} !== 17'h0) begin
      errors++;
      $display("FAIL reset_values: got gnt=%b owner=%0d data=%h v=%b busy=%b to=%b, expected all 0",
               gnt, bus_owner, bus_data, bus_valid, busy, timeout);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: got gnt=%b busy=%b, expected 0000/0", gnt, busy);
    end
  endtask

  // Masters answer a grant with one last beat in the second grant cycle.
  task automatic run_single_beats(input string name, input logic [3:0] reqs,
                                  input int n_ten, input int order [5]);
    logic [3:0] prev, exp_g;
    int         t, ph;
    data_in = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req = reqs; valid_in = 4'b0; last_in = 4'b0; prev = 4'b0;
    for (int k = 0; k < 3 * n_ten; k++) begin
      tick();
      t  = k / 3;
      ph = k % 3;
      exp_g = (ph < 2) ? (4'b0001 << order[t]) : 4'b0000;
      checks++;
      if (gnt !== exp_g || busy !== (|exp_g)) begin
        errors++;
        $display("FAIL %s gnt cycle %0d: got gnt=%b busy=%b, expected gnt=%b", name, k, gnt, busy, exp_g);
      end
      checks++;
      if (bus_valid !== (ph == 2)) begin
        errors++;
        $display("FAIL %s bus_valid cycle %0d: got %b, expected %b", name, k, bus_valid, ph == 2);
      end
      if (ph == 2) begin
        checks++;
        if (bus_data !== 8'(8'hA0 + order[t]) || bus_owner !== 2'(order[t])) begin
          errors++;
          $display("FAIL %s data cycle %0d: got data=%h owner=%0d, expected data=%h owner=%0d",
                   name, k, bus_data, bus_owner, 8'(8'hA0 + order[t]), order[t]);
        end
      end
      valid_in = gnt & prev;
      last_in  = gnt & prev;
      prev     = gnt;
    end
    req = 4'b0; valid_in = 4'b0; last_in = 4'b0;
    tick();
  endtask

  task automatic test_two_masters;
    int order [5] = '{0, 2, 0, 2, 0};
    do_reset();
    run_single_beats("two_masters", 4'b0101, 3, order);
  endtask

  task automatic test_back_to_back;
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    run_single_beats("back_to_back", 4'b1111, 5, order);
  endtask

  // Streams from master m; optional last on the 8th beat. Master 0 lanes carry noise.
  task automatic run_stream(input string name, input int m, input bit last8);
    logic [3:0] mbit;
    logic [7:0] base;
    bit         exp_to;
    do_reset();
    mbit = 4'b0001 << m;
    base = 8'(8'h10 * m);
    req = mbit;
    tick();
    checks++;
    if (gnt !== mbit) begin
      errors++;
      $display("FAIL %s grant: got %b, expected %b", name, gnt, mbit);
    end
    valid_in = mbit | 4'b0001; last_in = 4'b0001;
    data_in[7:0] = 8'hFF;
    data_in[m*8 +: 8] = base;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_to = (k == 8) && !last8;
      checks++;
      if (bus_valid !== 1'b1 || bus_data !== 8'(base + k - 1)) begin
        errors++;
        $display("FAIL %s beat %0d: got v=%b data=%h, expected v=1 data=%h", name, k, bus_valid, bus_data, 8'(base + k - 1));
      end
      checks++;
      if (timeout !== exp_to || gnt !== ((k == 8) ? 4'b0 : mbit)) begin
        errors++;
        $display("FAIL %s end beat %0d: got timeout=%b gnt=%b, expected timeout=%b gnt=%b",
                 name, k, timeout, gnt, exp_to, (k == 8) ? 4'b0 : mbit);
      end
      data_in[m*8 +: 8] = 8'(base + k);
      if (k == 7 && last8) last_in = last_in | mbit;
      if (k == 8) begin
        req = 4'b0; valid_in = 4'b0; last_in = 4'b0;
      end
    end
    tick();
    checks++;
    if (timeout !== 1'b0 || bus_valid !== 1'b0 || gnt !== 4'b0) begin
      errors++;
      $display("FAIL %s after_end: got timeout=%b v=%b gnt=%b, expected 0/0/0000", name, timeout, bus_valid, gnt);
    end
  endtask

  task automatic test_timeout;
    run_stream("timeout", 1, 1'b0);
  endtask

  task automatic test_last_at_limit;
    run_stream("last_at_limit", 2, 1'b1);
  endtask

  task automatic test_abort;
    do_reset();
    req = 4'b1000;
    tick();
    valid_in = 4'b1000; data_in[31:24] = 8'h30;
    tick();
    checks++;
    if (bus_valid !== 1'b1 || bus_data !== 8'h30 || gnt !== 4'b1000 || bus_owner !== 2'd3) begin
      errors++;
      $display("FAIL abort_first_beat: got v=%b data=%h gnt=%b owner=%0d, expected 1/30/1000/3",
               bus_valid, bus_data, gnt, bus_owner);
    end
    req = 4'b0000; data_in[31:24] = 8'h31;
    tick();
    checks++;
    if (bus_valid !== 1'b0 || bus_data !== 8'h30 || gnt !== 4'b0 || busy !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL abort_drop: got v=%b data=%h gnt=%b busy=%b to=%b, expected 0/30/0000/0/0",
               bus_valid, bus_data, gnt, busy, timeout);
    end
    valid_in = 4'b0;
    tick();
  endtask

  task automatic test_async_reset;
    do_reset();
    req = 4'b0110;
    tick();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL async_pre_grant: got %b, expected 0010", gnt);
    end
    valid_in = 4'b0010; data_in[15:8] = 8'h55;
    tick();
    checks++;
    if (bus_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL async_pre_beat: got v=%b busy=%b, expected 1/1", bus_valid, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0 || bus_valid !== 1'b0 || busy !== 1'b0 || bus_data !== 8'h0) begin
      errors++;
      $display("FAIL async_reset: got gnt=%b v=%b busy=%b data=%h, expected 0000/0/0/00", gnt, bus_valid, busy, bus_data);
    end
    valid_in = 4'b0;
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0010 || bus_owner !== 2'd1) begin
      errors++;
      $display("FAIL async_regrant: got gnt=%b owner=%0d, expected 0010/1", gnt, bus_owner);
    end
    req = 4'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_two_masters();
    test_back_to_back();
    test_timeout();
    test_last_at_limit();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
